// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and the
// counter saturation constant macro.
`ifndef PULSE_METER_PKG_SV
`define PULSE_METER_PKG_SV

// All-ones value of a w-bit counter, evaluated in 64 bits so w=32 is safe.
`define CNT_MAX(w) ((64'd1 << (w)) - 64'd1)

package pulse_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

`endif

// File: rtl/pulse_period_meter_edge_sync.sv
// Rising-edge detector for pulse_in. Define PULSE_SYNC_EN to place a 2-FF
// synchroniser in front of the detector for asynchronous inputs.
module edge_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pulse_in,
    output logic pulse_edge
);

    logic pulse_s;
    logic pulse_d_reg;

`ifdef PULSE_SYNC_EN
    logic sync_1_reg;
    logic sync_2_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_1_reg <= 1'b0;
            sync_2_reg <= 1'b0;
        end else begin
            sync_1_reg <= pulse_in;
            sync_2_reg <= sync_1_reg;
        end
    end

    assign pulse_s = sync_2_reg;
`else
    assign pulse_s = pulse_in;
`endif

    // pulse_d resets low so a high input at reset release reads as an edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pulse_d_reg <= 1'b0;
        end else begin
            pulse_d_reg <= pulse_s;
        end
    end

    assign pulse_edge = pulse_s & ~pulse_d_reg;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures sys_clk cycles between rising edges of pulse_in and flags lock to
// EXP_PERIOD +/- TOL. Optional input synchroniser: PULSE_SYNC_EN.
module pulse_period_meter #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 6,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    import pulse_meter_pkg::*;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(`CNT_MAX(CNT_W));
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);
    // Tolerance window in CNT_W+1 bits; the low bound clamps at zero.
    localparam logic [CNT_W:0] TOL_LO =
        (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : (CNT_W+1)'(0);
    localparam logic [CNT_W:0] TOL_HI = (CNT_W+1)'(EXP_PERIOD + TOL);

    logic pulse_edge;

    meter_state_t       state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [CNT_W-1:0]   period_reg, period_next;
    logic               vld_reg,    vld_next;
    logic               timeout_reg, timeout_next;
    logic [MATCH_W-1:0] match_reg,  match_next;
    logic               locked_reg, locked_next;

    logic [CNT_W:0] cnt_ext;
    logic           in_tol;

    edge_sync u_edge_sync (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pulse_in   (pulse_in),
        .pulse_edge (pulse_edge)
    );

    assign cnt_ext = {1'b0, cnt_reg};
    assign in_tol  = (cnt_ext >= TOL_LO) && (cnt_ext <= TOL_HI);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        vld_next     = 1'b0;
        timeout_next = 1'b0;
        match_next   = match_reg;
        locked_next  = locked_reg;

        case (state_reg)
            IDLE: begin
                if (pulse_edge) begin
                    cnt_next   = CNT_ONE;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // An edge takes priority over saturation in the same cycle.
                if (pulse_edge) begin
                    period_next = cnt_reg;
                    vld_next    = 1'b1;
                    cnt_next    = CNT_ONE;
                    if (in_tol) begin
                        if (match_reg != MATCH_FULL) begin
                            match_next = match_reg + 1'b1;
                        end
                    end else begin
                        match_next = '0;
                    end
                    locked_next = (match_next == MATCH_FULL);
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    timeout_next = 1'b1;
                    match_next   = '0;
                    locked_next  = 1'b0;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            period_reg  <= '0;
            vld_reg     <= 1'b0;
            timeout_reg <= 1'b0;
            match_reg   <= '0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            vld_reg     <= vld_next;
            timeout_reg <= timeout_next;
            match_reg   <= match_next;
            locked_reg  <= locked_next;
        end
    end

    assign period     = period_reg;
    assign period_vld = vld_reg;
    assign locked     = locked_reg;
    assign timeout    = timeout_reg;

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the period, in sys_clk cycles, between successive rising edges of a single-bit pulse or clock input. It reports each period and asserts a lock flag once the period matches an expected divide ratio for a configured number of consecutive measurements. It is the checking end of the clock-divider chain: it consumes a divider's flag/clock output (e.g. a divide-by-six flag) and confirms it on-board or in simulation.

## Interface
- CNT_W, 16: width of the period counter and of `period`.
- EXP_PERIOD, 6: expected period in sys_clk cycles. Must be in 2..2^CNT_W-2.
- TOL, 0: accepted absolute deviation from EXP_PERIOD.
- LOCK_CNT, 4: consecutive in-tolerance periods required to assert `locked`. Must be ≥1.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- pulse_in  input  1  measured signal; only rising edges are significant.
- period  output  CNT_W  last measured period, held between measurements.
- period_vld  output  1  one-cycle strobe; `period` updated this cycle.
- locked  output  1  EXP_PERIOD±TOL seen LOCK_CNT times in a row.
- timeout  output  1  one-cycle strobe; counter saturated with no edge.

## Operation
- Input path: `pulse_s` is `pulse_in` (macro off) or its 2-FF synchronised copy (macro on). `pulse_d` is `pulse_s` delayed one cycle. `edge = pulse_s & ~pulse_d`.
- Two-state FSM:
  - IDLE: on `edge`, set cnt←1 and go to MEASURE.
  - MEASURE, on `edge`: period←cnt; period_vld←1; cnt←1. The FSM stays in MEASURE.
  - MEASURE, no edge, cnt < 2^CNT_W-1: cnt←cnt+1.
  - MEASURE, no edge, cnt = 2^CNT_W-1: timeout←1; match←0; locked←0; cnt←0; go to IDLE. `period` is not updated.
- Lock counter `match` (width clog2(LOCK_CNT+1)) updates on each period_vld:
  - In tolerance, i.e. |cnt−EXP_PERIOD| ≤ TOL: match←min(match+1, LOCK_CNT).
  - Otherwise: match←0.
  - locked = (next match == LOCK_CNT). It is registered and updates in the same cycle as period_vld.
- Tolerance arithmetic is unsigned with CNT_W+1 bits. Compare cnt ≥ EXP−TOL (clamped at 0) and cnt ≤ EXP+TOL. There is no wrap.
- A constant-high or constant-low pulse_in produces no edges, so it ends in a timeout.
- Duty cycle is irrelevant: a one-cycle flag and a 50% clock of equal period give identical results.

## Timing
- Reset values: period=0, period_vld=0, locked=0, timeout=0, state=IDLE, cnt=0, match=0, pulse_d=0, sync flops=0.
- A high pulse_in at reset release counts as an edge and only arms the FSM.
- period_vld latency from the first sys_clk edge that samples pulse_in high is 1 cycle with the macro off and 3 cycles with it on.
- First period_vld comes on the second edge after reset or timeout. The first interval is always measured.
- Edge and counter saturation in the same cycle: the edge wins and a normal measurement occurs.
- Reset mid-measurement: everything clears at once. No strobe is emitted.
- Back-to-back edges 2 cycles apart give period=2. Edges on consecutive cycles are impossible because `edge` needs a low sample in between.

## Configuration
- PULSE_SYNC_EN defined: a 2-FF synchroniser sits in front of edge detect. Use this for asynchronous or external pulse_in. Adds 2 cycles latency; measured periods are unchanged.
- PULSE_SYNC_EN undefined: pulse_in is used directly. It must be driven synchronously by sys_clk logic, e.g. an on-chip divider.

## Structure
- Shared package/include `pulse_meter_pkg`: FSM state encoding (IDLE=1'b0, MEASURE=1'b1) and a `CNT_MAX(w)` constant macro.
- One sub-module, `edge_sync`. It holds the optional synchroniser, `pulse_d` and the `edge` output, and is parameterised by the same macro.
- The top level holds the FSM, counter, tolerance compare and lock logic.

## Test plan
- Divide-by-six flag (one-cycle high every 6 cycles), defaults, macro off → period_vld every 6 cycles with period=6. locked rises with the 4th period_vld and stays high.
- Lock established, then one interval of 7 cycles → that strobe reports period=7 and locked falls in the same cycle. The next four 6-cycle intervals re-lock.
- TOL=1, alternating intervals 5,7,6 → all in tolerance; locked after 4 strobes.
- CNT_W=4, pulse_in stuck low after one edge → timeout strobe 15 cycles after the arming edge. Then IDLE, locked=0, period unchanged. Fresh edges re-arm.
- 50%-duty clock with period 6 and macro on → period=6. First period_vld is 3 cycles after the second rising edge.
- sys_rst asserted mid-interval with locked=1 → all outputs 0 immediately. No spurious period_vld after release.
